coherence_bus_controller: RTL and testbench
===========================================

// Module: coherence_bus_controller
// PURPOSE
//  Shared-bus side of the snooping MESI protocol: the responder to per-core cache bus requests.
//  - Latches one-cycle BusRd/BusRdX pulses from up to NUM_CORES caches.
//  - Arbitrates round-robin and broadcasts a snoop to every other cache.
//  - Sources fill data from a Modified owner (writing it back to memory) or from memory,
//    then returns it to the requester as a one-cycle data-valid pulse.
// PARAMETERS
//  NUM_CORES      4   number of attached caches (>=2)
//  ADDRESS_WIDTH  6   block address width
//  DATA_WIDTH     32  data word width
//  IDW            $clog2(NUM_CORES)  grant id width (derived)
// PORTS
//  clk               in   1              clock
//  reset             in   1              asynchronous, active-high
//  req_valid         in   NUM_CORES      per-core bus request pulse
//  req_type          in   2*NUM_CORES    per-core 01=BusRd, 10=BusRdX; slice i = [2i+1:2i]
//  req_addr          in   AW*NUM_CORES   per-core request address
//  snoop_resp_valid  in   NUM_CORES      per-core snoop response valid
//  snoop_resp_hit    in   NUM_CORES      per-core snoop hit
//  snoop_resp_state  in   2*NUM_CORES    per-core pre-snoop state: 00 I, 01 S, 10 E, 11 M
//  snoop_resp_data   in   DW*NUM_CORES   per-core snooped line data
//  snoop_valid       out  NUM_CORES      per-core snoop strobe; requester bit always 0
//  snoop_type        out  2              broadcast snoop type (copy of granted req_type)
//  snoop_addr        out  AW             broadcast snoop address
//  fill_valid        out  NUM_CORES      one-hot fill pulse to requester
//  fill_data         out  DW             fill data, shared by all cores
//  mem_req_valid     out  1              memory request, held until accepted
//  mem_req_we        out  1              1 = writeback, 0 = read
//  mem_req_addr      out  AW             memory address
//  mem_wdata         out  DW             writeback data
//  mem_req_ready     in   1              memory accepts request
//  mem_resp_valid    in   1              read data valid
//  mem_rdata         in   DW             read data
//  busy              out  1              transaction in flight (state != IDLE)
//  grant_id          out  IDW            core currently served
//  err_overflow      out  1              sticky: request pulse dropped
//  err_multi_owner   out  1              sticky: more than one snoop responder in M
// BEHAVIOUR
//  Reset: all outputs 0; pending bits clear; state IDLE; rr pointer 0; sticky errors clear.
//  Request capture
//   - pending[i] set on req_valid[i] pulse; type/addr captured in per-core registers.
//   - Pulse while pending[i]=1: dropped, err_overflow set.
//   - Pulse in the same cycle as fill_valid[i]: accepted as a new request.
//  FSM: IDLE -> SNOOP -> COLLECT -> (WB) -> (RD) -> FILL -> IDLE
//   IDLE: if any pending, grant the first pending core at or after rr, wrapping.
//         Clear its pending bit; rr <= grant+1 (mod NUM_CORES).
//   SNOOP: one cycle. snoop_valid = all-ones with the grant bit cleared.
//          snoop_type/addr = granted request.
//   COLLECT: exactly one cycle after SNOOP. A core is an owner when
//            snoop_resp_valid & hit & state==11 for a non-grant core; non-grant responses otherwise ignored.
//            Owner exists: latch its data (lowest index on ties; err_multi_owner if >1) -> WB.
//            No owner: -> RD.
//   WB: mem_req_valid=1, we=1, wdata=owner data. On mem_req_ready -> FILL with owner data.
//   RD: mem_req_valid=1, we=0, held until ready. Then deassert and wait mem_resp_valid;
//       latch mem_rdata -> FILL.
//   FILL: fill_valid[grant]=1 and fill_data for one cycle -> IDLE.
//  Latency (idle bus, ready=1, 1-cycle memory):
//   - Owner hit: grant -> fill in 4 cycles.
//   - Memory read: grant -> fill in 5 cycles.
//  Only one transaction in flight; other pending requests wait, never lost.
//  mem_req_* outputs stable while mem_req_valid=1 and !mem_req_ready.
//  Reset mid-transaction drops the transaction and all pending requests; mem_req_valid drops asynchronously.
// TESTING
//  1. Core0 BusRd A=0x14, no hits, mem returns 0xDEADBEEF
//     -> snoop_valid=4'b1110; mem read 0x14; fill_valid=4'b0001, fill_data=0xDEADBEEF.
//  2. Core2 BusRdX 0x08; core1 hits M with 0x55
//     -> mem write 0x08/0x55; fill_valid=4'b0100, fill_data=0x55; no mem read.
//  3. Cores 0,1,3 pulse the same cycle, rr=0
//     -> grants 0,1,3 in order; next lone core0 request granted only after 3.
//  4. Core1 pulses twice while pending -> one fill only; err_overflow=1.
//  5. Two cores report M in COLLECT -> lowest-index data used; err_multi_owner=1.
//  6. Reset during RD with mem_req_ready=0 -> all outputs 0; later requests served normally.

Source files
------------

// File: rtl/coherence_bus_controller.sv
// coherence_bus_controller: shared-bus responder for a snooping MESI system.
// Captures per-core BusRd/BusRdX pulses, grants one core at a time in
// round-robin order, broadcasts a snoop to the other caches, and sources the
// fill from a Modified owner (with writeback) or from memory.
module coherence_bus_controller #(
    parameter int NUM_CORES     = 4,
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int IDW           = $clog2(NUM_CORES)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CORES-1:0]                 req_valid,
    input  logic [2*NUM_CORES-1:0]               req_type,
    input  logic [ADDRESS_WIDTH*NUM_CORES-1:0]   req_addr,
    input  logic [NUM_CORES-1:0]                 snoop_resp_valid,
    input  logic [NUM_CORES-1:0]                 snoop_resp_hit,
    input  logic [2*NUM_CORES-1:0]               snoop_resp_state,
    input  logic [DATA_WIDTH*NUM_CORES-1:0]      snoop_resp_data,
    output logic [NUM_CORES-1:0]                 snoop_valid,
    output logic [1:0]                           snoop_type,
    output logic [ADDRESS_WIDTH-1:0]             snoop_addr,
    output logic [NUM_CORES-1:0]                 fill_valid,
    output logic [DATA_WIDTH-1:0]                fill_data,
    output logic                                 mem_req_valid,
    output logic                                 mem_req_we,
    output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic                                 busy,
    output logic [IDW-1:0]                       grant_id,
    output logic                                 err_overflow,
    output logic                                 err_multi_owner
);

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        COLLECT,
        WB,
        RD_REQ,
        RD_WAIT,
        FILL
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [NUM_CORES-1:0]      pending;
    logic [1:0]                type_q [NUM_CORES];
    logic [ADDRESS_WIDTH-1:0]  addr_q [NUM_CORES];

    logic [IDW-1:0]            rr;
    logic [IDW-1:0]            grant_sel;
    logic [IDW-1:0]            scan_idx;
    logic                      scan_found;
    logic                      grant_fire;

    logic [1:0]                cur_type;
    logic [ADDRESS_WIDTH-1:0]  cur_addr;
    logic [DATA_WIDTH-1:0]     line_data;

    logic                      owner_found;
    logic                      multi_owner;
    logic [DATA_WIDTH-1:0]     owner_data;

    // Round-robin pick: first pending core at or after rr, wrapping around.
    always_comb begin
        grant_sel  = rr;
        scan_idx   = rr;
        scan_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            scan_idx = IDW'((32'(rr) + k) % NUM_CORES);
            if (!scan_found && pending[scan_idx]) begin
                grant_sel  = scan_idx;
                scan_found = 1'b1;
            end
        end
    end

    assign grant_fire = (state == IDLE) && (|pending);

    // Owner detection: non-grant snoop responders that hit in Modified; lowest index wins.
    always_comb begin
        owner_found = 1'b0;
        multi_owner = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if ((32'(grant_id) != i) && snoop_resp_valid[i] && snoop_resp_hit[i] &&
                (snoop_resp_state[2*i +: 2] == 2'b11)) begin
                if (owner_found) begin
                    multi_owner = 1'b1;
                end else begin
                    owner_found = 1'b1;
                    owner_data  = snoop_resp_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Request capture: a pulse on an already-pending core is dropped and flagged.
    // The granted core's pending bit is cleared at grant, so it is never pending
    // while its own pulse arrives later in the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            err_overflow <= 1'b0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                type_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            if (grant_fire) begin
                pending[grant_sel] <= 1'b0;
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (req_valid[i]) begin
                    if (pending[i]) begin
                        err_overflow <= 1'b1;
                    end else begin
                        pending[i] <= 1'b1;
                        type_q[i]  <= req_type[2*i +: 2];
                        addr_q[i]  <= req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    end
                end
            end
        end
    end

    // Transaction datapath: grant bookkeeping, granted request copy, fill data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id        <= '0;
            rr              <= '0;
            cur_type        <= '0;
            cur_addr        <= '0;
            line_data       <= '0;
            err_multi_owner <= 1'b0;
        end else begin
            if (grant_fire) begin
                grant_id <= grant_sel;
                rr       <= IDW'((32'(grant_sel) + 32'd1) % NUM_CORES);
                cur_type <= type_q[grant_sel];
                cur_addr <= addr_q[grant_sel];
            end
            if (state == COLLECT) begin
                if (owner_found) begin
                    line_data <= owner_data;
                end
                if (multi_owner) begin
                    err_multi_owner <= 1'b1;
                end
            end
            if ((state == RD_WAIT) && mem_resp_valid) begin
                line_data <= mem_rdata;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pending) state_next = SNOOP;
            SNOOP:   state_next = COLLECT;
            COLLECT: state_next = owner_found ? WB : RD_REQ;
            WB:      if (mem_req_ready) state_next = FILL;
            RD_REQ:  if (mem_req_ready) state_next = RD_WAIT;
            RD_WAIT: if (mem_resp_valid) state_next = FILL;
            FILL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs, decoded from state so reset clears them immediately.
    always_comb begin
        snoop_valid   = '0;
        snoop_type    = '0;
        snoop_addr    = '0;
        fill_valid    = '0;
        fill_data     = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        busy          = (state != IDLE);
        case (state)
            SNOOP: begin
                snoop_valid           = '1;
                snoop_valid[grant_id] = 1'b0;
                snoop_type            = cur_type;
                snoop_addr            = cur_addr;
            end
            WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = cur_addr;
                mem_wdata     = line_data;
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = cur_addr;
            end
            FILL: begin
                fill_valid[grant_id] = 1'b1;
                fill_data            = line_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_controller.sv
// Testbench for coherence_bus_controller: directed protocol scenarios followed
// by randomized transactions, checked against a transaction-level bus model.
module tb_coherence_bus_controller;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [2*N-1:0]    req_type;
    logic [AW*N-1:0]   req_addr;
    logic [N-1:0]      snoop_resp_valid;
    logic [N-1:0]      snoop_resp_hit;
    logic [2*N-1:0]    snoop_resp_state;
    logic [DW*N-1:0]   snoop_resp_data;
    logic [N-1:0]      snoop_valid;
    logic [1:0]        snoop_type;
    logic [AW-1:0]     snoop_addr;
    logic [N-1:0]      fill_valid;
    logic [DW-1:0]     fill_data;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic [1:0]        grant_id;
    logic              err_overflow;
    logic              err_multi_owner;

    always #5 clk = ~clk;

    coherence_bus_controller #(
        .NUM_CORES     (N),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_type         (req_type),
        .req_addr         (req_addr),
        .snoop_resp_valid (snoop_resp_valid),
        .snoop_resp_hit   (snoop_resp_hit),
        .snoop_resp_state (snoop_resp_state),
        .snoop_resp_data  (snoop_resp_data),
        .snoop_valid      (snoop_valid),
        .snoop_type       (snoop_type),
        .snoop_addr       (snoop_addr),
        .fill_valid       (fill_valid),
        .fill_data        (fill_data),
        .mem_req_valid    (mem_req_valid),
        .mem_req_we       (mem_req_we),
        .mem_req_addr     (mem_req_addr),
        .mem_wdata        (mem_wdata),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_rdata        (mem_rdata),
        .busy             (busy),
        .grant_id         (grant_id),
        .err_overflow     (err_overflow),
        .err_multi_owner  (err_multi_owner)
    );

    int compared   = 0;
    int mismatched = 0;

    // Bus model: per-core outstanding request, round-robin pointer, sticky errors.
    bit              mpend [N];
    logic [1:0]      mtype [N];
    logic [AW-1:0]   maddr [N];
    int              mrr;
    bit              exp_ovf;
    bit              exp_mo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mpend[i] = 1'b0;
            mtype[i] = '0;
            maddr[i] = '0;
        end
        mrr     = 0;
        exp_ovf = 1'b0;
        exp_mo  = 1'b0;
    endtask

    task automatic model_grant(output int g);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mrr + k) % N;
            if (g < 0 && mpend[c]) g = c;
        end
        if (g >= 0) begin
            mpend[g] = 1'b0;
            mrr      = (g + 1) % N;
        end
    endtask

    // Advance to the next negedge; request pulses last exactly one cycle.
    task automatic tick();
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic apply_pulse(input logic [N-1:0] mask, input logic [2*N-1:0] types,
                               input logic [AW*N-1:0] addrs);
        req_valid = mask;
        req_type  = types;
        req_addr  = addrs;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (mpend[i]) begin
                    exp_ovf = 1'b1;
                end else begin
                    mpend[i] = 1'b1;
                    mtype[i] = types[2*i +: 2];
                    maddr[i] = addrs[i*AW +: AW];
                end
            end
        end
    endtask

    task automatic pulse_same(input logic [N-1:0] mask, input logic [1:0] t, input logic [AW-1:0] a);
        apply_pulse(mask, {N{t}}, {N{a}});
    endtask

    task automatic pulse_rand(input logic [N-1:0] mask);
        logic [2*N-1:0]  ty;
        logic [AW*N-1:0] ad;
        for (int i = 0; i < N; i++) begin
            ty[2*i +: 2]   = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            ad[i*AW +: AW] = AW'($urandom);
        end
        apply_pulse(mask, ty, ad);
    endtask

    task automatic check_mem(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("mem_req_we", 64'(mem_req_we), 64'(we));
        check("mem_req_addr", 64'(mem_req_addr), 64'(a));
        if (we) check("mem_wdata", 64'(mem_wdata), 64'(d));
    endtask

    // Serve one whole transaction: wait for the snoop, answer it, play memory, check the fill.
    task automatic serve(input int ready_delay, input int resp_delay,
                         input logic [N-1:0] rv, input logic [N-1:0] rh,
                         input logic [2*N-1:0] rs, input logic [DW*N-1:0] rd,
                         input logic [DW-1:0] memdata,
                         input logic [N-1:0] pc, input logic [N-1:0] pf);
        int            g;
        bit            seen;
        bit            own;
        int            cnt;
        logic [DW-1:0] expd;
        logic [N-1:0]  onehot;
        logic [N-1:0]  sv_exp;
        logic [AW-1:0] ga;

        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (snoop_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("snoop_seen", 64'(seen), 64'd1);
        if (!seen) return;

        model_grant(g);
        if (g < 0) begin
            check("unexpected_snoop", 64'(snoop_valid), 64'd0);
            return;
        end
        onehot = N'(1) << g;
        sv_exp = ~onehot;
        ga     = maddr[g];
        check("snoop_valid", 64'(snoop_valid), 64'(sv_exp));
        check("snoop_type", 64'(snoop_type), 64'(mtype[g]));
        check("snoop_addr", 64'(snoop_addr), 64'(ga));
        check("grant_id", 64'(grant_id), 64'(g));
        check("busy_snoop", 64'(busy), 64'd1);

        // COLLECT cycle: caches answer now.
        tick();
        snoop_resp_valid = rv;
        snoop_resp_hit   = rh;
        snoop_resp_state = rs;
        snoop_resp_data  = rd;
        if (pc != '0) pulse_rand(pc);
        own  = 1'b0;
        cnt  = 0;
        expd = memdata;
        for (int i = 0; i < N; i++) begin
            if (i != g && rv[i] && rh[i] && rs[2*i +: 2] == 2'b11) begin
                cnt++;
                if (!own) begin
                    own  = 1'b1;
                    expd = rd[i*DW +: DW];
                end
            end
        end
        if (cnt > 1) exp_mo = 1'b1;
        check("collect_snoop_off", 64'(snoop_valid), 64'd0);
        check("collect_no_mem", 64'(mem_req_valid), 64'd0);

        // WB or RD_REQ: request held until accepted.
        tick();
        snoop_resp_valid = '0;
        snoop_resp_hit   = '0;
        snoop_resp_state = '0;
        snoop_resp_data  = '0;
        for (int d = 0; d < ready_delay; d++) begin
            check_mem(own, ga, expd);
            tick();
        end
        mem_req_ready = 1'b1;
        check_mem(own, ga, expd);
        tick();
        mem_req_ready = 1'b0;

        if (!own) begin
            for (int d = 0; d < resp_delay; d++) begin
                check("rd_wait_req_off", 64'(mem_req_valid), 64'd0);
                check("rd_wait_no_fill", 64'(fill_valid), 64'd0);
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = memdata;
            check("rd_wait_req_off", 64'(mem_req_valid), 64'd0);
            tick();
            mem_resp_valid = 1'b0;
            mem_rdata      = $urandom;
        end

        check("fill_valid", 64'(fill_valid), 64'(onehot));
        check("fill_data", 64'(fill_data), 64'(expd));
        check("fill_mem_off", 64'(mem_req_valid), 64'd0);
        if (pf != '0) pulse_rand(pf);

        tick();
        check("fill_end", 64'(fill_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("err_overflow", 64'(err_overflow), 64'(exp_ovf));
        check("err_multi_owner", 64'(err_multi_owner), 64'(exp_mo));
    endtask

    initial begin
        int            g;
        bit            seen;
        bit            any;
        logic [N-1:0]  m;
        logic [DW*N-1:0] rdv;

        reset            = 1'b1;
        req_valid        = '0;
        req_type         = '0;
        req_addr         = '0;
        snoop_resp_valid = '0;
        snoop_resp_hit   = '0;
        snoop_resp_state = '0;
        snoop_resp_data  = '0;
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b0;
        mem_rdata        = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_snoop_valid", 64'(snoop_valid), 64'd0);
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_err_overflow", 64'(err_overflow), 64'd0);
        check("rst_err_multi", 64'(err_multi_owner), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 1: core0 BusRd 0x14, nobody hits, memory supplies 0xDEADBEEF
        pulse_same(4'b0001, 2'b01, 6'h14);
        serve(0, 0, '0, '0, '0, '0, 32'hDEADBEEF, '0, '0);

        // 2: core2 BusRdX 0x08, core1 owns in M with 0x55; requester's own M answer ignored
        pulse_same(4'b0100, 2'b10, 6'h08);
        serve(0, 0, 4'b0110, 4'b0110, 8'b00_11_11_00,
              {32'h0, 32'h0000_0BAD, 32'h0000_0055, 32'h0}, 32'hFFFF_FFFF, '0, '0);

        // 4: core1 pulses again while pending -> dropped, one fill only
        pulse_same(4'b0010, 2'b01, 6'h21);
        tick();
        pulse_same(4'b0010, 2'b10, 6'h22);
        serve(1, 1, '0, '0, '0, '0, 32'h1234_5678, '0, '0);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("t4_single_fill", 64'(busy), 64'd0);
        end

        // 5: cores 1 and 3 both claim M -> core1 data, multi-owner flagged
        pulse_same(4'b0001, 2'b01, 6'h30);
        serve(2, 0, 4'b1110, 4'b1110, 8'b11_01_11_00,
              {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0}, 32'hAAAA_AAAA, '0, '0);

        // 6: reset while the read request is stalled
        pulse_same(4'b0100, 2'b01, 6'h2A);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (snoop_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_snoop_seen", 64'(seen), 64'd1);
        model_grant(g);
        check("t6_grant", 64'(grant_id), 64'(g));
        tick();
        pulse_rand(4'b1000);
        tick();
        check("t6_rd_req", 64'(mem_req_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_mem_req_async", 64'(mem_req_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_grant_id", 64'(grant_id), 64'd0);
        check("t6_err_overflow", 64'(err_overflow), 64'd0);
        check("t6_err_multi", 64'(err_multi_owner), 64'd0);
        check("t6_mem_addr", 64'(mem_req_addr), 64'd0);
        model_reset();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("t6_pending_dropped", 64'(busy), 64'd0);
        end

        // 3: cores 0,1,3 together from rr=0; lone core0 request during core1 waits behind core3
        pulse_rand(4'b1011);
        serve(0, 0, '0, '0, '0, '0, 32'h0000_0A00, '0, '0);
        serve(0, 0, '0, '0, '0, '0, 32'h0000_0A01, 4'b0001, '0);
        serve(0, 0, '0, '0, '0, '0, 32'h0000_0A03, '0, '0);
        serve(0, 0, '0, '0, '0, '0, 32'h0000_0A10, '0, '0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            any = 1'b0;
            for (int i = 0; i < N; i++) if (mpend[i]) any = 1'b1;
            if (!any) begin
                m = N'($urandom_range(1, (1 << N) - 1));
                pulse_rand(m);
            end
            rdv = {$urandom, $urandom, $urandom, $urandom};
            serve($urandom_range(0, 2), $urandom_range(0, 2),
                  N'($urandom), N'($urandom), (2*N)'($urandom), rdv, $urandom,
                  ($urandom_range(0, 1) == 1) ? N'($urandom) : '0,
                  ($urandom_range(0, 2) == 0) ? N'($urandom) : '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
